// File: rtl/par_serial_tx_pkg.sv
// Shared symbol constants and link-state encoding for the serial TX and its RX-side aligner.
// Holds only constants, types and a width helper; there is no logic and no latency here.
package par_serial_tx_pkg;

  localparam logic [7:0] COM_BYTE_DEFAULT  = 8'hBC;
  localparam logic [7:0] IDLE_BYTE_DEFAULT = 8'h7C;
  localparam int         N_COM_DEFAULT     = 4;

  typedef enum logic {
    TX_SYNC = 1'b0,
    TX_RUN  = 1'b1
  } tx_state_e;

  // Counter width able to hold n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/par_serial_tx_piso8.sv
// 8-bit parallel-load, shift-left register; ser_o is the registered MSB.
// Load takes priority over shift, and a shift fills the LSB with 0. There is no backpressure.
module piso8 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic [7:0] par_i,
  output logic       ser_o
);

  logic [7:0] shreg_q;
  logic [7:0] shreg_d;

  always_comb begin
    shreg_d = load_i ? par_i : {shreg_q[6:0], 1'b0};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= 8'h00;
    end else begin
      shreg_q <= shreg_d;
    end
  end

  assign ser_o = shreg_q[7];

endmodule

// File: rtl/par_serial_tx.sv
// Byte-to-serial transmitter: sends N_COM comma symbols, then data or idle symbols MSB first, with no gaps.
// A byte loaded at edge k leaves from edge k to edge k+7; ready_out is high only in the cycle before a load in RUN.
module par_serial_tx
  import par_serial_tx_pkg::*;
#(
  parameter logic [7:0] COM_BYTE  = COM_BYTE_DEFAULT,
  parameter logic [7:0] IDLE_BYTE = IDLE_BYTE_DEFAULT,
  parameter int         N_COM     = N_COM_DEFAULT
) (
  input  logic       clk32f,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       data_out,
  output logic       active_out,
  output logic [7:0] tx_count
);

  localparam int               COM_W    = cnt_width(N_COM);
  localparam logic [COM_W-1:0] COM_LAST = COM_W'(N_COM - 1);

  tx_state_e        state_q, state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [COM_W-1:0] com_cnt_q, com_cnt_d;
  logic [7:0]       tx_count_q, tx_count_d;
  logic             load;
  logic             accept;
  logic [7:0]       sym;

  assign load       = (bit_cnt_q == 3'd7);
  assign ready_out  = (state_q == TX_RUN) && load;
  assign accept     = valid_in && ready_out;
  assign active_out = (state_q == TX_RUN);
  assign tx_count   = tx_count_q;

  always_comb begin
    state_d   = state_q;
    com_cnt_d = com_cnt_q;
    sym       = COM_BYTE;
    case (state_q)
      TX_SYNC: begin
        if (load) begin
          if (com_cnt_q == COM_LAST) begin
            state_d = TX_RUN;
          end else begin
            com_cnt_d = com_cnt_q + COM_W'(1);
          end
        end
      end
      TX_RUN: begin
        // sym is only consumed on a load edge, and accept already implies one.
        sym = accept ? data_in : IDLE_BYTE;
      end
    endcase
  end

  always_comb begin
    bit_cnt_d  = load ? 3'd0 : bit_cnt_q + 3'd1;
    tx_count_d = accept ? tx_count_q + 8'd1 : tx_count_q;
  end

  always_ff @(posedge clk32f or negedge reset) begin
    if (!reset) begin
      state_q    <= TX_SYNC;
      bit_cnt_q  <= 3'd7;
      com_cnt_q  <= '0;
      tx_count_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      com_cnt_q  <= com_cnt_d;
      tx_count_q <= tx_count_d;
    end
  end

  piso8 u_piso8 (
    .clk    (clk32f),
    .rst_n  (reset),
    .load_i (load),
    .par_i  (sym),
    .ser_o  (data_out)
  );

endmodule

// File: tb/tb_par_serial_tx.sv
// Randomised scoreboard bench for par_serial_tx: a symbol-slot model queues expected bits and a monitor compares them.
module tb_par_serial_tx;

  localparam logic [7:0] COM  = 8'hBC;
  localparam logic [7:0] IDLE = 8'h7C;
  localparam int         NCOM = 4;

  logic       clk32f = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       valid_in = 1'b0;
  logic       ready_out;
  logic       data_out;
  logic       active_out;
  logic [7:0] tx_count;

  int checks = 0;
  int passed = 0;

  bit         exp_bits[$];
  int         n_edges = 0;
  logic [7:0] exp_tx = 8'h00;
  logic [7:0] model_sym;
  bit         exp_bit;

  par_serial_tx dut (
    .clk32f     (clk32f),
    .reset      (reset),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
    .data_out   (data_out),
    .active_out (active_out),
    .tx_count   (tx_count)
  );

  always #5 clk32f = ~clk32f;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Each link slot is 8 clocks; the first NCOM slots after release carry commas, later ones carry data or idle.
  always @(posedge clk32f or negedge reset) begin
    if (!reset) begin
      exp_bits.delete();
      n_edges = 0;
      exp_tx  = 8'h00;
    end else begin
      if (n_edges % 8 == 0) begin
        if (n_edges < NCOM * 8) begin
          model_sym = COM;
        end else if (valid_in) begin
          model_sym = data_in;
          exp_tx    = exp_tx + 8'd1;
        end else begin
          model_sym = IDLE;
        end
        for (int i = 7; i >= 0; i--) exp_bits.push_back(model_sym[i]);
      end
      n_edges++;
    end
  end

  always @(negedge clk32f) begin
    if (!reset || n_edges == 0) begin
      check("rst_data_out", data_out, 0);
      check("rst_active_out", active_out, 0);
      check("rst_ready_out", ready_out, 0);
      check("rst_tx_count", tx_count, 0);
    end else begin
      if (exp_bits.size() == 0) begin
        check("sb_underflow", 1, 0);
      end else begin
        exp_bit = exp_bits.pop_front();
        check("data_out", data_out, exp_bit);
      end
      check("ready_out", ready_out, (n_edges % 8 == 0) && (n_edges >= NCOM * 8));
      check("active_out", active_out, n_edges > (NCOM - 1) * 8);
      check("tx_count", tx_count, exp_tx);
    end
  end

  task automatic cyc(input logic v, input logic [7:0] d);
    @(negedge clk32f);
    valid_in = v;
    data_in  = d;
  endtask

  // Drives v/d into the next data-phase load edge; other cycles optionally carry random, ignorable valids.
  task automatic send_slot(input logic v, input logic [7:0] d, input bit noise);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk32f);
      if (n_edges % 8 == 0 && n_edges >= NCOM * 8) begin
        valid_in = v;
        data_in  = d;
        return;
      end
      valid_in = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      data_in  = 8'($urandom);
    end
    check("slot_timeout", 0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 reset = 1'b0;
    repeat (5) @(negedge clk32f);
    reset = 1'b1;

    repeat (48) cyc(1'b0, 8'($urandom));
    check("sync_tx_count", tx_count, 0);
    check("sync_active", active_out, 1);

    send_slot(1'b1, 8'hFF, 1'b0);
    send_slot(1'b1, 8'hEE, 1'b0);
    send_slot(1'b1, 8'hDD, 1'b0);
    send_slot(1'b1, 8'hCC, 1'b0);
    cyc(1'b0, 8'h00);
    check("burst4_tx_count", tx_count, 4);

    for (int i = 0; i < 16; i++) begin
      @(negedge clk32f);
      if (n_edges % 8 == 4) begin
        valid_in = 1'b1;
        data_in  = 8'h55;
        break;
      end
      valid_in = 1'b0;
    end
    repeat (12) cyc(1'b0, 8'h00);
    check("ignored55_tx_count", tx_count, 4);

    send_slot(1'b1, 8'hAA, 1'b0);
    send_slot(1'b0, 8'h00, 1'b0);
    send_slot(1'b1, 8'h99, 1'b0);
    cyc(1'b0, 8'h00);
    check("aa_idle_99_tx_count", tx_count, 6);

    for (int i = 0; i < 150; i++) begin
      send_slot(1'($urandom_range(0, 1)), 8'($urandom), 1'b1);
    end

    send_slot(1'b1, 8'hFF, 1'b0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk32f);
      valid_in = 1'b0;
      if (n_edges % 8 == 5) break;
    end
    check("pre_rst_active", active_out, 1);
    check("pre_rst_data_out", data_out, 1);
    #2 reset = 1'b0;
    #1;
    check("async_rst_data_out", data_out, 0);
    check("async_rst_active", active_out, 0);
    check("async_rst_tx_count", tx_count, 0);
    check("async_rst_ready", ready_out, 0);
    repeat (3) @(negedge clk32f);
    reset = 1'b1;
    repeat (40) cyc(1'b0, 8'($urandom));
    check("resync_tx_count", tx_count, 0);

    for (int i = 0; i < 256; i++) begin
      send_slot(1'b1, 8'($urandom), 1'b1);
      if (i == 127) check("wrap_half_tx_count", tx_count, 127);
    end
    cyc(1'b0, 8'h00);
    check("wrap_tx_count", tx_count, 0);
    check("wrap_active", active_out, 1);

    repeat (16) cyc(1'b0, 8'h00);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
